// File: rtl/button_debounce_arbiter.sv
// button_debounce_arbiter: per-button 2-flop synchronizers feeding one shared
// stability timer. A round-robin FSM (IDLE/TIMING/COMMIT) lends the timer to one
// changed button at a time and commits its level after DELAY_CYCLES stable cycles.
// Optional feature macro: BUTTON_DEBOUNCE_EVENT_EN enables the press/release
// pulse outputs; when undefined they are tied to zero.
module button_debounce_arbiter #(
    parameter int N_BTN        = 4,
    parameter int DELAY_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         button_in,
    output logic [N_BTN-1:0]         button_out,
    output logic [N_BTN-1:0]         press_pulse,
    output logic [N_BTN-1:0]         release_pulse,
    output logic                     busy,
    output logic [$clog2(N_BTN)-1:0] sel
);

    localparam int SEL_W = $clog2(N_BTN);
    localparam int CNT_W = $clog2(DELAY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_BTN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TIMING,
        ST_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [N_BTN-1:0]   r_sync1;
    logic [N_BTN-1:0]   r_sync2;
    logic [N_BTN-1:0]   r_button_out;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_rr;
    logic               r_target;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_BTN-1:0]   w_cand;
    logic [SEL_W-1:0]   w_pick;
    logic [SEL_W-1:0]   w_sel_next;
    logic               w_bounce;

    // Two-flop synchronizer per raw button input.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= button_in;
            r_sync2 <= r_sync1;
        end
    end

    // Candidate scan: first changed button at or after the round-robin pointer.
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin : rr_scan
        int idx;
        w_cand = r_sync2 ^ r_button_out;
        w_pick = r_rr;
        idx    = 0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            idx = int'(r_rr) + k;
            if (idx >= N_BTN) idx = idx - N_BTN;
            if (w_cand[idx]) w_pick = SEL_W'(idx);
        end
    end

    assign w_bounce   = (r_sync2[r_sel] != r_target);
    assign w_sel_next = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (|w_cand) w_state_next = ST_TIMING;
            ST_TIMING: begin
                if (w_bounce)               w_state_next = ST_IDLE;
                else if (r_cnt == CNT_LAST) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: the timer is allocated in every state except IDLE.
    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    // Timer ownership, stability counter, round-robin pointer and committed levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel        <= '0;
            r_rr         <= '0;
            r_target     <= 1'b0;
            r_cnt        <= '0;
            r_button_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_cand) begin
                        r_sel    <= w_pick;
                        r_target <= r_sync2[w_pick];
                        r_cnt    <= '0;
                    end
                end
                ST_TIMING: begin
                    if (w_bounce)               r_rr  <= w_sel_next;
                    else if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_COMMIT: begin
                    r_button_out[r_sel] <= r_target;
                    r_rr                <= w_sel_next;
                end
                default: ;
            endcase
        end
    end

    assign button_out = r_button_out;
    assign sel        = r_sel;

`ifdef BUTTON_DEBOUNCE_EVENT_EN
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;

    // One-cycle event pulses, aligned with the committed level change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= '0;
            r_release <= '0;
            if (r_state == ST_COMMIT) begin
                if (r_target) r_press[r_sel]   <= 1'b1;
                else          r_release[r_sel] <= 1'b1;
            end
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
`else
    assign press_pulse   = '0;
    assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_button_debounce_arbiter.sv
// Self-checking bench for button_debounce_arbiter (N_BTN=4, DELAY_CYCLES=8).
// Pulse expectations follow BUTTON_DEBOUNCE_EVENT_EN: zero when it is undefined.
module tb_button_debounce_arbiter;

    localparam int N_BTN = 4;
    localparam int DELAY = 8;

    logic       clk;
    logic       reset;
    logic [3:0] button_in;
    logic [3:0] button_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       busy;
    logic [1:0] sel;

    int n_checks = 0;
    int n_errors = 0;

    button_debounce_arbiter #(
        .N_BTN       (N_BTN),
        .DELAY_CYCLES(DELAY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button_in),
        .button_out   (button_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .busy         (busy),
        .sel          (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        int         ticks;
        logic [3:0] exp_out;
        logic       exp_busy;
        logic [1:0] exp_sel;
        logic [3:0] exp_press;
        logic [3:0] exp_rel;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [3:0] ev(input logic [3:0] v);
`ifdef BUTTON_DEBOUNCE_EVENT_EN
        return v;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [3:0] e_out, input logic e_busy,
                             input logic [1:0] e_sel, input logic [3:0] e_p, input logic [3:0] e_r);
        check({name, ".out"},   32'(button_out),    32'(e_out));
        check({name, ".busy"},  32'(busy),          32'(e_busy));
        check({name, ".sel"},   32'(sel),           32'(e_sel));
        check({name, ".press"}, 32'(press_pulse),   32'(e_p));
        check({name, ".rel"},   32'(release_pulse), 32'(e_r));
    endtask

    task automatic do_reset();
        button_in = 4'b0000;
        reset     = 1'b0;
        tick(2);
        reset     = 1'b1;
    endtask

    initial begin
        // Clean press of bit0, then contention on bits 1..3 from rr=1, then release of bit2.
        vecs[0]  = '{4'b0001,  2, 4'b0000, 1'b0, 2'd0, 4'b0000,     4'b0000};
        vecs[1]  = '{4'b0001,  1, 4'b0000, 1'b1, 2'd0, 4'b0000,     4'b0000};
        vecs[2]  = '{4'b0001,  8, 4'b0000, 1'b1, 2'd0, 4'b0000,     4'b0000};
        vecs[3]  = '{4'b0001,  1, 4'b0001, 1'b0, 2'd0, ev(4'b0001), 4'b0000};
        vecs[4]  = '{4'b0001,  1, 4'b0001, 1'b0, 2'd0, 4'b0000,     4'b0000};
        vecs[5]  = '{4'b1111, 12, 4'b0011, 1'b0, 2'd1, ev(4'b0010), 4'b0000};
        vecs[6]  = '{4'b1111,  1, 4'b0011, 1'b1, 2'd2, 4'b0000,     4'b0000};
        vecs[7]  = '{4'b1111,  9, 4'b0111, 1'b0, 2'd2, ev(4'b0100), 4'b0000};
        vecs[8]  = '{4'b1111, 10, 4'b1111, 1'b0, 2'd3, ev(4'b1000), 4'b0000};
        vecs[9]  = '{4'b1011, 11, 4'b1111, 1'b1, 2'd2, 4'b0000,     4'b0000};
        vecs[10] = '{4'b1011,  1, 4'b1011, 1'b0, 2'd2, 4'b0000,     ev(4'b0100)};
        vecs[11] = '{4'b1011,  1, 4'b1011, 1'b0, 2'd2, 4'b0000,     4'b0000};

        // Reset state.
        button_in = 4'b0000;
        reset     = 1'b0;
        tick(2);
        check_all("reset", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);
        reset = 1'b1;

        // Table-driven sequence.
        for (int i = 0; i < 12; i++) begin
            button_in = vecs[i].btn;
            tick(vecs[i].ticks);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_busy,
                      vecs[i].exp_sel, vecs[i].exp_press, vecs[i].exp_rel);
        end

        // Bounce on bit1: 5 cycles high never commits; rr advances to 2.
        do_reset();
        button_in = 4'b0010;
        tick(3);
        check_all("bnc_start", 4'b0000, 1'b1, 2'd1, 4'b0000, 4'b0000);
        tick(2);
        button_in = 4'b0000;
        tick(2);
        check("bnc_hold.busy", 32'(busy), 32'd1);
        tick(1);
        check_all("bnc_abort", 4'b0000, 1'b0, 2'd1, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check($sformatf("bnc_quiet%0d", i), 32'({button_out, press_pulse, release_pulse, busy}), 32'd0);
        end
        // 4'b0110 from rr=2 must pick bit2 first, then bit1.
        button_in = 4'b0110;
        tick(3);
        check_all("bnc_rr", 4'b0000, 1'b1, 2'd2, 4'b0000, 4'b0000);
        tick(9);
        check_all("bnc_rr_c1", 4'b0100, 1'b0, 2'd2, ev(4'b0100), 4'b0000);
        tick(1);
        check_all("bnc_rr_next", 4'b0100, 1'b1, 2'd1, 4'b0000, 4'b0000);
        tick(9);
        check_all("bnc_rr_c2", 4'b0110, 1'b0, 2'd1, ev(4'b0010), 4'b0000);

        // Full contention from reset: bits commit 0,1,2,3 ten cycles apart.
        do_reset();
        button_in = 4'b1111;
        tick(11);
        check_all("cont_pre", 4'b0000, 1'b1, 2'd0, 4'b0000, 4'b0000);
        tick(1);
        check_all("cont_b0", 4'b0001, 1'b0, 2'd0, ev(4'b0001), 4'b0000);
        tick(1);
        check_all("cont_sel1", 4'b0001, 1'b1, 2'd1, 4'b0000, 4'b0000);
        tick(8);
        check("cont_b1_pre.out", 32'(button_out), 32'(4'b0001));
        tick(1);
        check_all("cont_b1", 4'b0011, 1'b0, 2'd1, ev(4'b0010), 4'b0000);
        tick(10);
        check_all("cont_b2", 4'b0111, 1'b0, 2'd2, ev(4'b0100), 4'b0000);
        tick(10);
        check_all("cont_b3", 4'b1111, 1'b0, 2'd3, ev(4'b1000), 4'b0000);

        // Reset at counter=5 discards the pending press; held button re-commits.
        do_reset();
        button_in = 4'b0100;
        tick(8);
        check_all("mrst_timing", 4'b0000, 1'b1, 2'd2, 4'b0000, 4'b0000);
        reset = 1'b0;
        #1;
        check_all("mrst_async", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);
        tick(1);
        check_all("mrst_hold", 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000);
        reset = 1'b1;
        tick(11);
        check_all("mrst_pre", 4'b0000, 1'b1, 2'd2, 4'b0000, 4'b0000);
        tick(1);
        check_all("mrst_commit", 4'b0100, 1'b0, 2'd2, ev(4'b0100), 4'b0000);
        tick(1);
        check_all("mrst_after", 4'b0100, 1'b0, 2'd2, 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
